ws281x_chain_transmitter: RTL and testbench

Streams a chain of WS281x pixels from a valid/ready pixel interface onto one serial data line. Bit timing, pixel width and latch gap are parameters; slow (400 kHz) or fast (800 kHz) bit rate is selected per frame at run time. A one-entry holding buffer allows back-to-back pixels with no gap. After the frame's last pixel, the block appends the reset/latch low period.

---
 rtl/ws281x_chain_transmitter.sv | 201 ++++++++++++++++++++
 tb/tb_ws281x_chain_transmitter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ws281x_chain_transmitter.sv
// WS281x pixel-chain serializer: valid/ready pixel input, one-entry holding buffer, latch gap after the frame.
// Optional macro WS281X_UNDERRUN_DETECT_EN adds underrunOUT and aborts a frame whose gap reaches the latch time.
module ws281x_chain_transmitter #(
    parameter int CLOCK_SPEED    = 50_000_000,
    parameter int BITS_PER_PIXEL = 24,
    parameter int T0H_NS         = 500,
    parameter int T1H_NS         = 1200,
    parameter int TBIT_NS        = 2500,
    parameter int TRESET_NS      = 50_000
) (
    input  logic                      clkIN,
    input  logic                      resetIN,
    input  logic [BITS_PER_PIXEL-1:0] pixelIN,
    input  logic                      lastIN,
    input  logic                      validIN,
    output logic                      readyOUT,
    input  logic                      fastIN,
    output logic                      busyOUT,
`ifdef WS281X_UNDERRUN_DETECT_EN
    output logic                      underrunOUT,
`endif
    output logic                      dataOUT
);

    localparam int MHZ    = CLOCK_SPEED / 1_000_000;
    localparam int S_T0H  = MHZ * T0H_NS / 1000;
    localparam int S_T1H  = MHZ * T1H_NS / 1000;
    localparam int S_TBIT = MHZ * TBIT_NS / 1000;
    localparam int F_T0H  = S_T0H / 2;
    localparam int F_T1H  = S_T1H / 2;
    localparam int F_TBIT = S_TBIT / 2;
    localparam int T_RST  = MHZ * TRESET_NS / 1000;
    localparam int MAX_CNT = (S_TBIT > T_RST) ? S_TBIT : T_RST;
    localparam int CW = $clog2(MAX_CNT);
    localparam int BW = $clog2(BITS_PER_PIXEL);
`ifdef WS281X_UNDERRUN_DETECT_EN
    localparam bit UNDERRUN_EN = 1'b1;
`else
    localparam bit UNDERRUN_EN = 1'b0;
`endif

    if (!(F_T0H >= 1 && F_T0H < F_T1H && F_T1H < F_TBIT &&
          (BITS_PER_PIXEL == 24 || BITS_PER_PIXEL == 32))) begin : g_bad_timing
        $error("ws281x_chain_transmitter: illegal timing or pixel-width parameters");
    end

    typedef enum logic [1:0] {IDLE, BIT, GAP, LATCH} state_t;

    state_t                    state_r;
    logic [CW-1:0]             cnt_r;
    logic [BW-1:0]             bit_idx_r;
    logic [BITS_PER_PIXEL-1:0] shift_r;
    logic                      last_flag_r;
    logic                      fast_r;
    logic                      buf_valid_r;
    logic [BITS_PER_PIXEL-1:0] buf_pixel_r;
    logic                      buf_last_r;

    logic                      accept_s;
    logic                      load_s;
    logic                      bit_end_s;
    logic                      pixel_end_s;
    logic                      gap_timeout_s;
    logic [CW-1:0]             cnt_next_s;
    logic [CW-1:0]             high_s;
    logic [CW-1:0]             bit_last_s;

    function automatic logic [CW-1:0] high_time(input logic one, input logic fast);
        logic [CW-1:0] t;
        case ({fast, one})
            2'b00:   t = CW'(S_T0H);
            2'b01:   t = CW'(S_T1H);
            2'b10:   t = CW'(F_T0H);
            2'b11:   t = CW'(F_T1H);
            default: t = CW'(S_T0H);
        endcase
        return t;
    endfunction

    // Handshake, bit/pixel boundaries and the load decision shared by buffer and sequencer.
    always_comb begin
        accept_s      = validIN && readyOUT;
        bit_last_s    = fast_r ? CW'(F_TBIT - 1) : CW'(S_TBIT - 1);
        bit_end_s     = (cnt_r == bit_last_s);
        pixel_end_s   = bit_end_s && (bit_idx_r == BW'(BITS_PER_PIXEL - 1));
        cnt_next_s    = cnt_r + CW'(1);
        high_s        = high_time(shift_r[BITS_PER_PIXEL-1], fast_r);
        load_s        = buf_valid_r && ((state_r == IDLE) || (state_r == GAP) ||
                                        ((state_r == BIT) && pixel_end_s));
        gap_timeout_s = UNDERRUN_EN && (state_r == GAP) && (cnt_r == CW'(T_RST - 1));
    end

    // Holding buffer; readyOUT mirrors the buffer's next emptiness so it is a clean register.
    always_ff @(posedge clkIN) begin
        if (resetIN) begin
            buf_valid_r <= 1'b0;
            buf_pixel_r <= '0;
            buf_last_r  <= 1'b0;
            readyOUT    <= 1'b0;
        end else if (accept_s) begin
            buf_valid_r <= 1'b1;
            buf_pixel_r <= pixelIN;
            buf_last_r  <= lastIN;
            readyOUT    <= 1'b0;
        end else if (load_s) begin
            buf_valid_r <= 1'b0;
            readyOUT    <= 1'b1;
        end else begin
            readyOUT    <= ~buf_valid_r;
        end
    end

    // Frame sequencer: loads pixels, times each bit, then runs the gap or latch period.
    always_ff @(posedge clkIN) begin
        if (resetIN) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            bit_idx_r   <= '0;
            shift_r     <= '0;
            last_flag_r <= 1'b0;
            fast_r      <= 1'b0;
            dataOUT     <= 1'b0;
            busyOUT     <= 1'b0;
        end else if (load_s) begin
            // Bit rate is chosen only when a frame starts from IDLE.
            fast_r      <= (state_r == IDLE) ? fastIN : fast_r;
            shift_r     <= buf_pixel_r;
            last_flag_r <= buf_last_r;
            cnt_r       <= '0;
            bit_idx_r   <= '0;
            dataOUT     <= 1'b1;
            busyOUT     <= 1'b1;
            state_r     <= BIT;
        end else begin
            case (state_r)
                IDLE: begin
                    dataOUT <= 1'b0;
                    busyOUT <= 1'b0;
                end
                BIT: begin
                    if (!bit_end_s) begin
                        cnt_r   <= cnt_next_s;
                        dataOUT <= (cnt_next_s < high_s);
                    end else if (!pixel_end_s) begin
                        shift_r   <= {shift_r[BITS_PER_PIXEL-2:0], 1'b0};
                        bit_idx_r <= bit_idx_r + BW'(1);
                        cnt_r     <= '0;
                        dataOUT   <= 1'b1;
                    end else if (last_flag_r) begin
                        state_r <= LATCH;
                        cnt_r   <= '0;
                        dataOUT <= 1'b0;
                    end else begin
                        state_r <= GAP;
                        cnt_r   <= '0;
                        dataOUT <= 1'b0;
                    end
                end
                GAP: begin
                    if (gap_timeout_s) begin
                        state_r <= IDLE;
                        cnt_r   <= '0;
                        busyOUT <= 1'b0;
                    end else begin
                        cnt_r <= UNDERRUN_EN ? cnt_next_s : cnt_r;
                    end
                end
                LATCH: begin
                    if (cnt_r == CW'(T_RST - 1)) begin
                        state_r <= IDLE;
                        cnt_r   <= '0;
                        busyOUT <= 1'b0;
                    end else begin
                        cnt_r <= cnt_next_s;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    dataOUT <= 1'b0;
                    busyOUT <= 1'b0;
                end
            endcase
        end
    end

`ifdef WS281X_UNDERRUN_DETECT_EN
    // Sticky underrun flag: set entering GAP, cleared when a latch completes normally.
    always_ff @(posedge clkIN) begin
        if (resetIN) begin
            underrunOUT <= 1'b0;
        end else if ((state_r == BIT) && pixel_end_s && !buf_valid_r && !last_flag_r) begin
            underrunOUT <= 1'b1;
        end else if ((state_r == LATCH) && (cnt_r == CW'(T_RST - 1))) begin
            underrunOUT <= 1'b0;
        end else begin
            underrunOUT <= underrunOUT;
        end
    end
`endif

endmodule

// File: tb/tb_ws281x_chain_transmitter.sv
// Randomized bench for ws281x_chain_transmitter: decodes the serial line into pulses and checks them
// against pixel bit values and the nominal WS281x timing at the default parameters.
module tb_ws281x_chain_transmitter;

    localparam int BPP    = 24;
    localparam int S_T0H  = 25;
    localparam int S_T1H  = 60;
    localparam int S_TBIT = 125;
    localparam int F_T0H  = 12;
    localparam int F_T1H  = 30;
    localparam int F_TBIT = 62;
    localparam int T_RST  = 2500;

    typedef logic [BPP-1:0] px_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    px_t  pixel = '0;
    logic last = 1'b0;
    logic valid = 1'b0;
    logic ready;
    logic fast = 1'b0;
    logic busy;
    logic data;
`ifdef WS281X_UNDERRUN_DETECT_EN
    logic underrun;
`endif

    ws281x_chain_transmitter dut (
        .clkIN    (clk),
        .resetIN  (reset),
        .pixelIN  (pixel),
        .lastIN   (last),
        .validIN  (valid),
        .readyOUT (ready),
        .fastIN   (fast),
        .busyOUT  (busy),
`ifdef WS281X_UNDERRUN_DETECT_EN
        .underrunOUT (underrun),
`endif
        .dataOUT  (data)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_value(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Line monitor: pulse rise times, high lengths, busy falls and readyOUT rises, in negedge counts.
    int   ncyc = 0;
    int   rise_q[$];
    int   hi_q[$];
    int   bf_q[$];
    int   rdy_rise = 0;
    logic pd = 1'b0, pb = 1'b0, pr = 1'b0;
    always @(negedge clk) begin
        if (data && !pd) rise_q.push_back(ncyc);
        if (!data && pd) hi_q.push_back(ncyc - rise_q[$]);
        if (!busy && pb) bf_q.push_back(ncyc);
        if (ready && !pr) rdy_rise <= rdy_rise + 1;
        pd   <= data;
        pb   <= busy;
        pr   <= ready;
        ncyc <= ncyc + 1;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input px_t pix, input bit lst, input bit fst);
        int n = 0;
        pixel = pix;
        last  = lst;
        fast  = fst;
        valid = 1'b1;
        while (!ready && n < 20000) begin
            tick();
            n++;
        end
        check_value("accept_ready", ready, 1);
        tick();
    endtask

    task automatic wait_idle(input int bfb);
        int n = 0;
        while ((busy || bf_q.size() <= bfb) && n < 30000) begin
            tick();
            n++;
        end
        check_value("frame_end_in_time", (n < 30000), 1);
    endtask

    task automatic check_frame(input int hb, input int bfb, input px_t pix[$], input bit fst,
                               input int gap_pix);
        int t0, t1, tb, np, got, n, p, b, per;
        t0  = fst ? F_T0H : S_T0H;
        t1  = fst ? F_T1H : S_T1H;
        tb  = fst ? F_TBIT : S_TBIT;
        np  = pix.size();
        got = hi_q.size() - hb;
        check_value("pulse_count", got, np * BPP);
        n = (got < np * BPP) ? got : np * BPP;
        for (int k = 0; k < n; k++) begin
            p = k / BPP;
            b = BPP - 1 - (k % BPP);
            check_value($sformatf("high_p%0d_b%0d", p, b), hi_q[hb+k], pix[p][b] ? t1 : t0);
            if (k > 0) begin
                per = rise_q[hb+k] - rise_q[hb+k-1];
                if ((k % BPP == 0) && (p - 1 == gap_pix))
                    check_value("gap_length", (per >= tb + 500), 1);
                else
                    check_value($sformatf("period_p%0d_b%0d", p, b), per, tb);
            end
        end
        if (n == np * BPP && bf_q.size() > bfb)
            check_value("busy_fall", bf_q[bfb] - rise_q[hb + (np - 1) * BPP], BPP * tb + T_RST);
        else
            check_value("busy_fall_seen", 0, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        px_t fr[$];
        int  hb, bfb, rb, n, np;
        bit  fst;

        // Reset state and readyOUT one cycle after release.
        repeat (3) tick();
        check_value("rst_data", data, 0);
        check_value("rst_busy", busy, 0);
        check_value("rst_ready", ready, 0);
        reset = 1'b0;
        tick();
        check_value("ready_after_rst", ready, 1);
        check_value("idle_busy", busy, 0);
`ifdef WS281X_UNDERRUN_DETECT_EN
        check_value("rst_underrun", underrun, 0);
`endif

        // Single slow pixel A50000 with the latch period.
        hb = hi_q.size(); bfb = bf_q.size();
        fr = {24'hA50000};
        send(24'hA50000, 1'b1, 1'b0);
        valid = 1'b0;
        wait_idle(bfb);
        check_frame(hb, bfb, fr, 1'b0, -1);
        check_value("first_high", hi_q[hb], 60);
        check_value("second_high", hi_q[hb+1], 25);
        check_value("frame_length", bf_q[bfb] - rise_q[hb], 24 * 125 + 2500);

        // Three back-to-back random pixels with validIN held high.
        hb = hi_q.size(); bfb = bf_q.size(); rb = rdy_rise;
        fr = {};
        for (int i = 0; i < 3; i++) fr.push_back(px_t'($urandom));
        for (int i = 0; i < 3; i++) send(fr[i], (i == 2), 1'b0);
        valid = 1'b0;
        wait_idle(bfb);
        check_frame(hb, bfb, fr, 1'b0, -1);
        check_value("ready_pulses", rdy_rise - rb, 3);

        // Fast frame; fastIN dropped before the second pixel must not change the rate.
        hb = hi_q.size(); bfb = bf_q.size();
        fr = {24'hFFFFFF, px_t'($urandom)};
        send(fr[0], 1'b0, 1'b1);
        valid = 1'b0;
        repeat (10) tick();
        send(fr[1], 1'b1, 1'b0);
        valid = 1'b0;
        wait_idle(bfb);
        check_frame(hb, bfb, fr, 1'b1, -1);

        // Underrun: second pixel withheld for 500+ cycles.
        hb = hi_q.size(); bfb = bf_q.size();
        fr = {px_t'($urandom), px_t'($urandom)};
        send(fr[0], 1'b0, 1'b0);
        valid = 1'b0;
        n = 0;
        while (hi_q.size() < hb + BPP && n < 10000) begin tick(); n++; end
        repeat (S_TBIT + 500) tick();
        check_value("gap_busy", busy, 1);
        check_value("gap_data_low", data, 0);
`ifdef WS281X_UNDERRUN_DETECT_EN
        check_value("gap_underrun", underrun, 1);
`endif
        send(fr[1], 1'b1, 1'b0);
        valid = 1'b0;
        wait_idle(bfb);
        check_frame(hb, bfb, fr, 1'b0, 0);
`ifdef WS281X_UNDERRUN_DETECT_EN
        check_value("underrun_cleared", underrun, 0);

        // Gap longer than the latch time aborts the frame; underrun stays set.
        hb = hi_q.size(); bfb = bf_q.size();
        fr = {px_t'($urandom)};
        send(fr[0], 1'b0, 1'b0);
        valid = 1'b0;
        wait_idle(bfb);
        check_frame(hb, bfb, fr, 1'b0, -1);
        repeat (20) tick();
        check_value("abort_busy", busy, 0);
        check_value("abort_underrun", underrun, 1);
`endif

        // Reset during a high pulse with a pixel waiting in the buffer.
        send(px_t'($urandom) | 24'h800000, 1'b0, 1'b0);
        send(px_t'($urandom), 1'b1, 1'b0);
        valid = 1'b0;
        n = 0;
        while (!data && n < 2000) begin tick(); n++; end
        check_value("high_before_reset", data, 1);
        reset = 1'b1;
        tick();
        check_value("midrst_data", data, 0);
        check_value("midrst_busy", busy, 0);
        check_value("midrst_ready", ready, 0);
        reset = 1'b0;
        tick();
        check_value("midrst_ready_release", ready, 1);
`ifdef WS281X_UNDERRUN_DETECT_EN
        check_value("midrst_underrun", underrun, 0);
`endif
        hb = rise_q.size();
        repeat (300) tick();
        check_value("no_restart_pulses", rise_q.size() - hb, 0);
        check_value("no_restart_busy", busy, 0);

        // Random frames: 1-2 pixels, random rate.
        repeat (3) begin
            hb = hi_q.size(); bfb = bf_q.size();
            np = $urandom_range(1, 2);
            fst = 1'($urandom_range(0, 1));
            fr = {};
            for (int i = 0; i < np; i++) fr.push_back(px_t'($urandom));
            for (int i = 0; i < np; i++) send(fr[i], (i == np - 1), fst);
            valid = 1'b0;
            wait_idle(bfb);
            check_frame(hb, bfb, fr, fst, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
